// File: rtl/instruction_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, bubble instruction, ALU/immediate
// selectors and the ID/EX pipeline record.
package instruction_decode_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'b00,
      ALU_BRANCH = 2'b01,
      ALU_RTYPE  = 2'b10,
      ALU_IALU   = 2'b11
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_type_e;

   typedef struct packed {
      alu_op_e alu_op;
      logic    alu_src;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    reg_write;
      logic    branch;
      logic    jump;
      logic    illegal;
   } ctrl_t;

   // An all-zero record is the bubble.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic            funct7_5;
      ctrl_t           ctrl;
   } idex_t;

endpackage

// File: rtl/instruction_decode_if.sv
// Fetch/writeback inputs and ID/EX outputs of the decode stage.
interface instruction_decode_if;
   import instruction_decode_pkg::*;

   logic [XLEN-1:0] pc_in;
   logic [31:0]     instruction_in;
   logic            flush;
   logic            wb_reg_write;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;

   logic            stall_out;
   logic            valid_out;
   logic [XLEN-1:0] pc_out;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [XLEN-1:0] imm_out;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [4:0]      rd;
   logic [2:0]      funct3;
   logic            funct7_5;
   logic [1:0]      alu_op;
   logic            alu_src;
   logic            mem_read;
   logic            mem_write;
   logic            mem_to_reg;
   logic            reg_write;
   logic            branch;
   logic            jump;
   logic            illegal_out;

   modport master (
      output pc_in, instruction_in, flush, wb_reg_write, wb_rd, wb_data,
      input  stall_out, valid_out, pc_out, rs1_data, rs2_data, imm_out,
             rs1, rs2, rd, funct3, funct7_5, alu_op, alu_src, mem_read,
             mem_write, mem_to_reg, reg_write, branch, jump, illegal_out
   );

   modport slave (
      input  pc_in, instruction_in, flush, wb_reg_write, wb_rd, wb_data,
      output stall_out, valid_out, pc_out, rs1_data, rs2_data, imm_out,
             rs1, rs2, rd, funct3, funct7_5, alu_op, alu_src, mem_read,
             mem_write, mem_to_reg, reg_write, branch, jump, illegal_out
   );

endinterface

// File: rtl/instruction_decode_register_file.sv
// 32x32 integer register file: two async read ports, one sync write port,
// write-through bypass so a value written this cycle is visible to decode.
module instruction_decode_register_file
   import instruction_decode_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic            wr_en,
   input  logic [4:0]      wr_addr,
   input  logic [XLEN-1:0] wr_data
);

   logic [XLEN-1:0] regs [32];
   logic            wr_live;

   assign wr_live = wr_en && (wr_addr != 5'd0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wr_live) begin
         regs[wr_addr] <= wr_data;
      end
   end

   assign rs1_data = (rs1_addr == 5'd0)                  ? '0      :
                     (wr_live && (wr_addr == rs1_addr))  ? wr_data :
                                                           regs[rs1_addr];
   assign rs2_data = (rs2_addr == 5'd0)                  ? '0      :
                     (wr_live && (wr_addr == rs2_addr))  ? wr_data :
                                                           regs[rs2_addr];

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: IF/ID and ID/EX registers, control decode, immediate
// generation and load-use hazard detection around the register file.
module instruction_decode
   import instruction_decode_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   instruction_decode_if.slave  bus
);

   logic [XLEN-1:0] ifid_pc;
   logic [31:0]     ifid_instr;
   logic            ifid_valid;

   idex_t           idex;
   idex_t           idex_next;

   logic [6:0]      opcode;
   logic [4:0]      rs1_idx;
   logic [4:0]      rs2_idx;
   logic [4:0]      rd_idx;
   ctrl_t           ctrl;
   imm_type_e       imm_type;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            rs1_used;
   logic            rs2_used;
   logic            load_use;
   logic            stall;

   assign opcode  = ifid_instr[6:0];
   assign rd_idx  = ifid_instr[11:7];
   assign rs1_idx = ifid_instr[19:15];
   assign rs2_idx = ifid_instr[24:20];

   instruction_decode_register_file u_regfile (
      .clock    (clock),
      .reset    (reset),
      .rs1_addr (rs1_idx),
      .rs2_addr (rs2_idx),
      .rs1_data (rs1_val),
      .rs2_data (rs2_val),
      .wr_en    (bus.wb_reg_write),
      .wr_addr  (bus.wb_rd),
      .wr_data  (bus.wb_data)
   );

   always_comb begin
      ctrl     = '0;
      imm_type = IMM_NONE;
      rs1_used = 1'b1;
      rs2_used = 1'b0;
      case (opcode)
         OP_R: begin
            ctrl.alu_op    = ALU_RTYPE;
            ctrl.reg_write = 1'b1;
            rs2_used       = 1'b1;
         end
         OP_IALU: begin
            ctrl.alu_op    = ALU_IALU;
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            imm_type       = IMM_I;
         end
         OP_LOAD: begin
            ctrl.alu_src    = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            imm_type        = IMM_I;
         end
         OP_STORE: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
            imm_type       = IMM_S;
            rs2_used       = 1'b1;
         end
         OP_BRANCH: begin
            ctrl.alu_op = ALU_BRANCH;
            ctrl.branch = 1'b1;
            imm_type    = IMM_B;
            rs2_used    = 1'b1;
         end
         OP_JAL: begin
            ctrl.jump      = 1'b1;
            ctrl.reg_write = 1'b1;
            imm_type       = IMM_J;
            rs1_used       = 1'b0;
         end
         OP_JALR: begin
            ctrl.alu_src   = 1'b1;
            ctrl.jump      = 1'b1;
            ctrl.reg_write = 1'b1;
            imm_type       = IMM_I;
         end
         OP_LUI, OP_AUIPC: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            imm_type       = IMM_U;
            rs1_used       = 1'b0;
         end
         default: ctrl.illegal = 1'b1;
      endcase
   end

   always_comb begin
      case (imm_type)
         IMM_I:   imm = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
         IMM_S:   imm = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
         IMM_B:   imm = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                         ifid_instr[30:25], ifid_instr[11:8], 1'b0};
         IMM_U:   imm = {ifid_instr[31:12], 12'b0};
         IMM_J:   imm = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
                         ifid_instr[20], ifid_instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

   // A load in EX whose destination the instruction in ID actually reads.
   assign load_use = idex.valid && idex.ctrl.mem_read && (idex.rd != 5'd0) &&
                     ((rs1_used && (idex.rd == rs1_idx)) ||
                      (rs2_used && (idex.rd == rs2_idx)));
   assign stall    = load_use && !bus.flush;

   always_comb begin
      idex_next          = '0;
      idex_next.valid    = 1'b1;
      idex_next.pc       = ifid_pc;
      idex_next.rs1_data = rs1_val;
      idex_next.rs2_data = rs2_val;
      idex_next.imm      = imm;
      idex_next.rs1      = rs1_idx;
      idex_next.rs2      = rs2_idx;
      idex_next.rd       = rd_idx;
      idex_next.funct3   = ifid_instr[14:12];
      idex_next.funct7_5 = ifid_instr[30];
      idex_next.ctrl     = ctrl;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ifid_pc    <= '0;
         ifid_instr <= NOP_INSTR;
         ifid_valid <= 1'b0;
      end else if (bus.flush) begin
         ifid_pc    <= '0;
         ifid_instr <= NOP_INSTR;
         ifid_valid <= 1'b0;
      end else if (!stall) begin
         ifid_pc    <= bus.pc_in;
         ifid_instr <= bus.instruction_in;
         ifid_valid <= 1'b1;
      end
   end

   // Flushed or reset IF/ID contents never reach EX as a live instruction.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idex <= '0;
      end else if (bus.flush || stall || !ifid_valid) begin
         idex <= '0;
      end else begin
         idex <= idex_next;
      end
   end

   assign bus.stall_out   = stall;
   assign bus.valid_out   = idex.valid;
   assign bus.pc_out      = idex.pc;
   assign bus.rs1_data    = idex.rs1_data;
   assign bus.rs2_data    = idex.rs2_data;
   assign bus.imm_out     = idex.imm;
   assign bus.rs1         = idex.rs1;
   assign bus.rs2         = idex.rs2;
   assign bus.rd          = idex.rd;
   assign bus.funct3      = idex.funct3;
   assign bus.funct7_5    = idex.funct7_5;
   assign bus.alu_op      = idex.ctrl.alu_op;
   assign bus.alu_src     = idex.ctrl.alu_src;
   assign bus.mem_read    = idex.ctrl.mem_read;
   assign bus.mem_write   = idex.ctrl.mem_write;
   assign bus.mem_to_reg  = idex.ctrl.mem_to_reg;
   assign bus.reg_write   = idex.ctrl.reg_write;
   assign bus.branch      = idex.ctrl.branch;
   assign bus.jump        = idex.ctrl.jump;
   assign bus.illegal_out = idex.ctrl.illegal;

endmodule
